// File: rtl/stream_unpacker_vr.sv
// Wide-to-narrow valid-ready unpacker: one IN_W block in, RATIO (or fewer) OUT_W words out,
// most-significant word first, with a packet-last marker on the final word.
module stream_unpacker_vr #(
   parameter int IN_W  = 512,
   parameter int OUT_W = 32,
   parameter int RATIO = IN_W / OUT_W,
   parameter int CNT_W = $clog2(RATIO) + 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic             sync_rst,
   input  logic [IN_W-1:0]  data_in,
   input  logic             data_in_last,
   input  logic [CNT_W-1:0] data_in_words,
   input  logic             data_in_valid,
   output logic             data_in_ready,
   output logic [OUT_W-1:0] data_out,
   output logic             data_out_last,
   output logic             data_out_valid,
   input  logic             data_out_ready
);

   typedef enum logic {IDLE, EMIT} state_t;

   typedef struct packed {
      logic [IN_W-1:0]  data;
      logic             last;
      logic [CNT_W-1:0] words;
   } blk_t;

   state_t                      state;
   blk_t                        blk;
   blk_t                        blk_in;
   logic [CNT_W-1:0]            idx;
   logic [CNT_W-1:0]            in_words;
   logic [RATIO-1:0][OUT_W-1:0] word;
   logic                        at_last;
   logic                        out_shake;
   logic                        final_shake;
   logic                        in_shake;

   genvar k;
   generate
      for (k = 0; k < RATIO; k++) begin : g_word
         assign word[k] = blk.data[IN_W-1-k*OUT_W -: OUT_W];
      end
   endgenerate

   // Output word is a pure mux of registered state, so it cannot glitch with inputs.
   always_comb begin
      data_out = '0;
      for (int i = 0; i < RATIO; i++)
         if (idx == CNT_W'(i)) data_out = word[i];
   end

   // Out-of-range word counts mean "full block".
   assign in_words = (data_in_words == '0 || data_in_words > CNT_W'(RATIO)) ?
                     CNT_W'(RATIO) : data_in_words;
   assign blk_in   = '{data: data_in, last: data_in_last, words: in_words};

   assign at_last        = (idx == blk.words - CNT_W'(1));
   assign data_out_valid = (state == EMIT) && en;
   assign data_out_last  = blk.last && at_last && (state == EMIT);
   assign out_shake      = data_out_valid && data_out_ready;
   assign final_shake    = out_shake && at_last;
   // Accepting on the final shake lets the next block follow without a bubble.
   assign data_in_ready  = en && nrst && !sync_rst && ((state == IDLE) || final_shake);
   assign in_shake       = data_in_valid && data_in_ready;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
         blk   <= '0;
         idx   <= '0;
      end else if (sync_rst) begin
         state <= IDLE;
         blk   <= '0;
         idx   <= '0;
      end else if (en) begin
         case (state)
            IDLE: begin
               if (in_shake) begin
                  blk   <= blk_in;
                  idx   <= '0;
                  state <= EMIT;
               end
            end
            EMIT: begin
               if (final_shake) begin
                  idx <= '0;
                  if (in_shake) blk <= blk_in;
                  else          state <= IDLE;
               end else if (out_shake) begin
                  idx <= idx + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/stream_unpacker_vr.md
# stream_unpacker_vr

Wide-to-narrow valid-ready stream unpacker. It accepts one wide block per handshake and emits it as a sequence of narrow words on a valid-ready interface with a `last` marker. It is the transmit-side counterpart that feeds a narrow `fifo_vr`, for example when an accelerator's block-wide result is streamed out word-by-word. Its control conventions (`en`, `sync_rst`) match `fifo_vr`, so both blocks can share one control domain.

## Interface
- `IN_W`, 512: width of the input block; must be an integer multiple of `OUT_W`.
- `OUT_W`, 32: width of each output word.
- `RATIO`, `IN_W/OUT_W`: number of words per block (derived; do not override).
- `CNT_W`, `$clog2(RATIO)+1`: width of the word-count fields (derived).
- `clk`, in, 1: clock; all state updates on the rising edge.
- `nrst`, in, 1: reset; asynchronous, active-low.
- `en`, in, 1: enable; low freezes the block.
- `sync_rst`, in, 1: synchronous reset, active-high; same effect as `nrst`, applied at the clock edge.
- `data_in`, in, `IN_W`: input block.
- `data_in_last`, in, 1: block is the final block of its packet.
- `data_in_words`, in, `CNT_W`: number of valid words in the block, 1..`RATIO`; 0 or any value above `RATIO` is treated as `RATIO`.
- `data_in_valid`, in, 1: input block is valid.
- `data_in_ready`, out, 1: block can be accepted.
- `data_out`, out, `OUT_W`: current output word.
- `data_out_last`, out, 1: current word is the final word of the packet.
- `data_out_valid`, out, 1: output word is valid.
- `data_out_ready`, in, 1: downstream accepts the word.

## Operation
- Holding register `blk` (`IN_W`), flag `blk_last`, count `blk_words` (`CNT_W`), index `idx` (`CNT_W`), and a state bit with two states, IDLE and EMIT.
- Input shake = `data_in_valid && data_in_ready`. Output shake = `data_out_valid && data_out_ready`.
- Word ordering is most-significant first: word k = `blk[IN_W-1-k*OUT_W -: OUT_W]`.
- `data_out` = word `idx` of `blk`; it is driven from registers only (mux of registered state).
- `data_out_valid` = (state == EMIT) && `en`.
- `data_out_last` = `blk_last` && (`idx` == `blk_words`-1) && (state == EMIT).
- `final_shake` = output shake && (`idx` == `blk_words`-1).
- `data_in_ready` = `en` && !`sync_rst` && ((state == IDLE) || `final_shake`). This is combinational from `data_out_ready`; it provides zero-bubble block turnover.
- IDLE, on input shake: load `blk`, `blk_last`, `blk_words` (clamped), set `idx`=0, go to EMIT.
- EMIT, on an output shake that is not the final shake: `idx` <= `idx`+1.
- EMIT, on `final_shake`:
  - If an input shake occurs in the same cycle: load the new block, set `idx`=0, stay in EMIT.
  - Otherwise: go to IDLE with `idx`=0.
- `blk_last` does not change the state flow; it only qualifies `data_out_last`.
- `en` low: all registers hold, and `data_in_ready`=0 and `data_out_valid`=0. When `en` returns high, emission resumes at the same `idx`. No word is lost or duplicated.
- `nrst` low or `sync_rst` high: state IDLE, `idx`=0, `blk`=0, `blk_last`=0, `blk_words`=0. A block in mid-emission is discarded.

## Timing
- Reset values: `data_in_ready`=0, `data_out_valid`=0, `data_out_last`=0, `data_out`=0.
- After reset releases with `en`=1, `data_in_ready` is 1 in the first cycle.
- Latency: a block accepted at edge T presents word 0 with `data_out_valid`=1 from T+1.
- Throughput: 1 word per cycle sustained across back-to-back blocks when `data_out_ready` is held high. A W-word block occupies exactly W output cycles.
- Output stability: while `data_out_valid`=1 and `data_out_ready`=0, `data_out` and `data_out_last` are held stable.
- `data_in_valid` may rise at any time; the block never accepts input while in EMIT except on `final_shake`.
- `idx` never exceeds `RATIO`-1, and no wrap-around occurs.

## Test plan
Bench configuration: `IN_W`=128, `OUT_W`=32.
- Reset, then push `data_in`=0x11111111_22222222_33333333_44444444, words=4, last=1, with ready held high. Required: outputs 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles from T+1; `last` is asserted only on 0x44444444; `data_in_ready` is 1 on that cycle.
- Two back-to-back blocks (last=0 then last=1), with `data_in_valid` held high and output ready high. Required: 8 consecutive valid words with no bubble; `last` is asserted only on word 8.
- Partial block with words=2 and last=1. Required: only the two upper words are emitted, the second with `last`=1; the block returns to IDLE. A words=0 block emits 4 words.
- Output backpressure: `data_out_ready` toggles 1,0,0,1,... Required: a word is held stable while stalled; no word is dropped or repeated; `data_in_ready`=0 until the final word's shake.
- `en` dropped for 3 cycles after word 1 of a 4-word block. Required: valid and ready are 0 during the drop; word 2 is emitted when `en` returns.
- `sync_rst` pulsed mid-block after word 2, and separately `nrst` asserted asynchronously mid-block. Required: next-cycle valid=0 and ready=1 (`en`=1), and the next block's word 0 is emitted correctly.
